ser2par_nbits: RTL

Serial-to-parallel loader that feeds an N-bit register stage. It collects N serial bits, MSB first, into a word. It then presents the word with a valid/ready handshake. The downstream register's enable is out_valid & out_ready, and its d input is data_out. Backpressure stalls serial intake while a completed word waits to be accepted.

---
 rtl/ser2par_nbits.sv | 89 ++++++++
 1 files changed

// File: rtl/ser2par_nbits.sv
// Serial-to-parallel loader: gathers N bits MSB-first, then holds the word
// under a valid/ready handshake, stalling serial intake until it is taken.
module ser2par_nbits #(
  parameter int N = 8,
  localparam int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_bit,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          flush,
  output logic [N-1:0]  data_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] bit_cnt
);

  localparam logic [0:0]    COLLECT  = 1'b0;
  localparam logic [0:0]    FULL     = 1'b1;
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  logic [0:0]    state_q,     state_d;
  logic [N-1:0]  shift_q,     shift_d;
  logic [N-1:0]  data_q,      data_d;
  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] cnt_q,       cnt_d;
  logic [N-1:0]  shifted;

  assign shifted = {shift_q[N-2:0], in_bit};

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    data_d      = data_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    case (state_q)
      COLLECT: begin
        // flush outranks a coincident bit, including the word-completing one
        if (flush) begin
          cnt_d   = '0;
          shift_d = '0;
        end else if (in_valid) begin
          if (cnt_q == LAST_BIT) begin
            data_d      = shifted;
            out_valid_d = 1'b1;
            cnt_d       = '0;
            shift_d     = '0;
            state_d     = FULL;
          end else begin
            shift_d = shifted;
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      FULL: begin
        // data_q is left as-is after the transfer
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= COLLECT;
      shift_q     <= '0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready  = (state_q == COLLECT);
  assign out_valid = out_valid_q;
  assign data_out  = data_q;
  assign bit_cnt   = cnt_q;

endmodule
